// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin tristate bus arbiter:
// FSM state encoding and the default sizing of the block.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        OWN   = 2'd2,
        TURN  = 2'd3
    } arbState_t;

    localparam int DEFAULT_N_REQ    = 4;
    localparam int DEFAULT_MAX_HOLD = 16;
    localparam int DEFAULT_IDXW     = 2;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin winner selection: rotate the request vector so the slot
// after the last owner sits at bit 0, take the lowest set bit, then
// rotate the resulting index back into requester numbering.
module rr_priority_pick
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int IDXW  = DEFAULT_IDXW
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDXW-1:0]  pointer,
    output logic [IDXW-1:0]  winner,
    output logic             valid
);

    localparam logic [IDXW:0] NREQ_W = (IDXW + 1)'(N_REQ);

    logic [IDXW:0]      startIdx;
    logic [2*N_REQ-1:0] doubledReq;
    logic [N_REQ-1:0]   rotatedReq;
    logic [IDXW-1:0]    rotatedPos;
    logic [IDXW:0]      unrotatedSum;

    // The search starts one past the last owner, wrapping modulo N_REQ.
    // Doubling the vector turns the rotate into a plain right shift, and the
    // downward loop leaves the lowest set bit of the rotated vector in rotatedPos.
    always_comb begin
        startIdx = {1'b0, pointer} + 1'b1;
        if (startIdx >= NREQ_W) begin
            startIdx = '0;
        end
        doubledReq = {req, req};
        rotatedReq = N_REQ'(doubledReq >> startIdx);
        rotatedPos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotatedReq[i]) begin
                rotatedPos = IDXW'(i);
            end
        end
        unrotatedSum = {1'b0, rotatedPos} + startIdx;
        if (unrotatedSum >= NREQ_W) begin
            unrotatedSum = unrotatedSum - NREQ_W;
        end
        winner = unrotatedSum[IDXW-1:0];
        valid  = |req;
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for a shared 32-bit tristate bus. Produces one
// registered enable per requester's buffer bank, with a setup cycle
// before driving and an all-off turnaround cycle between owners so
// that two banks never drive the bus at the same time.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = DEFAULT_N_REQ,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int IDXW     = DEFAULT_IDXW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] bus_en,
    output logic [IDXW-1:0]  owner,
    output logic             bus_busy,
    output logic             preempt
);

    localparam int               HOLDW         = $clog2(MAX_HOLD + 1);
    localparam logic [HOLDW-1:0] HOLD_LIMIT    = HOLDW'(MAX_HOLD);
    localparam logic [N_REQ-1:0] ONE_HOT_BASE  = N_REQ'(1);
    localparam logic [IDXW-1:0]  LAST_IDX      = IDXW'(N_REQ - 1);

    arbState_t        state;
    arbState_t        nextState;
    logic [HOLDW-1:0] holdCount;
    logic [HOLDW-1:0] nextHold;
    logic [IDXW-1:0]  pointer;
    logic [IDXW-1:0]  nextPointer;
    logic [N_REQ-1:0] nextGnt;
    logic [N_REQ-1:0] nextBusEn;
    logic [IDXW-1:0]  nextOwner;
    logic             nextPreempt;

    logic [IDXW-1:0]  pickWinner;
    logic             pickValid;
    logic [N_REQ-1:0] ownerMask;
    logic             ownerReq;
    logic             othersPending;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDXW  (IDXW)
    ) picker (
        .req     (req),
        .pointer (pointer),
        .winner  (pickWinner),
        .valid   (pickValid)
    );

    // The owner's own request keeps the bus; any other request is only a
    // preemption trigger once the hold limit has been reached.
    assign ownerMask     = ONE_HOT_BASE << owner;
    assign ownerReq      = |(req & ownerMask);
    assign othersPending = |(req & ~ownerMask);

    // Next-state and next-output decode. Every output is computed here and
    // registered below, so gnt/bus_en never glitch at the bank enables.
    always_comb begin
        nextState   = state;
        nextGnt     = gnt;
        nextBusEn   = bus_en;
        nextOwner   = owner;
        nextPointer = pointer;
        nextHold    = holdCount;
        nextPreempt = 1'b0;

        case (state)
            IDLE, TURN: begin
                if (pickValid) begin
                    nextState   = GRANT;
                    nextGnt     = ONE_HOT_BASE << pickWinner;
                    nextBusEn   = '0;
                    nextOwner   = pickWinner;
                    nextPointer = pickWinner;
                    nextHold    = '0;
                end else begin
                    nextState = IDLE;
                    nextGnt   = '0;
                    nextBusEn = '0;
                    nextOwner = '0;
                    nextHold  = '0;
                end
            end

            GRANT: begin
                if (ownerReq) begin
                    nextState = OWN;
                    nextBusEn = gnt;
                    nextHold  = HOLDW'(1);
                end else begin
                    nextState = TURN;
                    nextGnt   = '0;
                    nextBusEn = '0;
                    nextOwner = '0;
                    nextHold  = '0;
                end
            end

            OWN: begin
                if (!ownerReq) begin
                    nextState = TURN;
                    nextGnt   = '0;
                    nextBusEn = '0;
                    nextOwner = '0;
                    nextHold  = '0;
                end else if ((holdCount == HOLD_LIMIT) && othersPending) begin
                    nextState   = TURN;
                    nextGnt     = '0;
                    nextBusEn   = '0;
                    nextOwner   = '0;
                    nextHold    = '0;
                    nextPreempt = 1'b1;
                end else if (holdCount != HOLD_LIMIT) begin
                    nextHold = holdCount + 1'b1;
                end
            end

            default: begin
                nextState = IDLE;
                nextGnt   = '0;
                nextBusEn = '0;
                nextOwner = '0;
                nextHold  = '0;
            end
        endcase
    end

    // State and output registers. The pointer resets to the last index so
    // requester 0 is first in line after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            bus_en    <= '0;
            owner     <= '0;
            bus_busy  <= 1'b0;
            preempt   <= 1'b0;
            holdCount <= '0;
            pointer   <= LAST_IDX;
        end else begin
            state     <= nextState;
            gnt       <= nextGnt;
            bus_en    <= nextBusEn;
            owner     <= nextOwner;
            bus_busy  <= |nextBusEn;
            preempt   <= nextPreempt;
            holdCount <= nextHold;
            pointer   <= nextPointer;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr with N_REQ=4, MAX_HOLD=16.
// Inputs change 1 time unit after a rising edge and outputs are
// checked at that same point, i.e. after the edge has settled.
module tb_bus_arbiter_rr;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] bus_en;
    logic [1:0] owner;
    logic       bus_busy;
    logic       preempt;

    int checkCount;
    int failCount;

    bus_arbiter_rr #(
        .N_REQ    (4),
        .MAX_HOLD (16),
        .IDXW     (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .bus_en   (bus_en),
        .owner    (owner),
        .bus_busy (bus_busy),
        .preempt  (preempt)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive reset/req, then advance one rising edge and let it settle.
    task automatic applyStimulus(input logic r, input logic [3:0] q);
        reset = r;
        req   = q;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] expGnt,
                            input logic [3:0] expBusEn, input logic [1:0] expOwner,
                            input logic expPreempt);
        checkOutput({tag, ".gnt"},      32'(gnt),      32'(expGnt));
        checkOutput({tag, ".bus_en"},   32'(bus_en),   32'(expBusEn));
        checkOutput({tag, ".owner"},    32'(owner),    32'(expOwner));
        checkOutput({tag, ".preempt"},  32'(preempt),  32'(expPreempt));
        checkOutput({tag, ".bus_busy"}, 32'(bus_busy), 32'(|expBusEn));
    endtask

    initial begin
        logic [3:0] oh;
        int         phase;
        int         slot;

        checkCount = 0;
        failCount  = 0;
        reset      = 1'b1;
        req        = 4'b0000;

        // Reset state
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b1, 4'b0000);
        checkAll("reset", 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Single requester 0: grant at cycle 1, drive at cycle 2, release at 5
        applyStimulus(1'b0, 4'b0001);
        checkAll("single.c1", 4'b0001, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0001);
        checkAll("single.c2", 4'b0001, 4'b0001, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0001);
        applyStimulus(1'b0, 4'b0001);
        applyStimulus(1'b0, 4'b0001);
        checkAll("single.c5", 4'b0001, 4'b0001, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        checkAll("single.c6", 4'b0000, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        checkAll("single.c7", 4'b0000, 4'b0000, 2'd0, 1'b0);

        // All four requesting: 18-cycle rotation (1 setup, 16 driving, 1 turnaround)
        applyStimulus(1'b1, 4'b1111);
        for (int k = 1; k <= 73; k++) begin
            applyStimulus(1'b0, 4'b1111);
            phase = (k - 1) % 18;
            slot  = ((k - 1) / 18) % 4;
            oh    = 4'b0001 << slot;
            checkAll($sformatf("rotate.c%0d", k),
                     (phase <= 16) ? oh : 4'b0000,
                     (phase >= 1 && phase <= 16) ? oh : 4'b0000,
                     (phase == 17) ? 2'd0 : 2'(slot),
                     phase == 17);
        end

        // Owner 1 releases while requester 3 arrives in the same cycle
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0010);
        checkAll("handoff.c1", 4'b0010, 4'b0000, 2'd1, 1'b0);
        applyStimulus(1'b0, 4'b0010);
        checkAll("handoff.c2", 4'b0010, 4'b0010, 2'd1, 1'b0);
        applyStimulus(1'b0, 4'b0010);
        applyStimulus(1'b0, 4'b1000);
        checkAll("handoff.turn", 4'b0000, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b1000);
        checkAll("handoff.grant3", 4'b1000, 4'b0000, 2'd3, 1'b0);
        applyStimulus(1'b0, 4'b1000);
        checkAll("handoff.own3", 4'b1000, 4'b1000, 2'd3, 1'b0);

        // Lone requester 2 for 100 cycles: never preempted
        applyStimulus(1'b1, 4'b0000);
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(1'b0, 4'b0100);
            checkAll($sformatf("lone.c%0d", k), 4'b0100,
                     (k >= 2) ? 4'b0100 : 4'b0000, 2'd2, 1'b0);
        end

        // Requester 0 drops during its setup cycle: no enable ever issued
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0001);
        checkAll("abort.grant", 4'b0001, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        checkAll("abort.turn", 4'b0000, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        checkAll("abort.idle", 4'b0000, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        checkAll("abort.idle2", 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Reset while owner 2 drives; afterwards requester 0 wins first
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0100);
        applyStimulus(1'b0, 4'b0100);
        checkAll("midreset.own2", 4'b0100, 4'b0100, 2'd2, 1'b0);
        applyStimulus(1'b0, 4'b0100);
        applyStimulus(1'b1, 4'b1111);
        checkAll("midreset.reset", 4'b0000, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b1111);
        checkAll("midreset.grant0", 4'b0001, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b1111);
        checkAll("midreset.own0", 4'b0001, 4'b0001, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
